// File: rtl/truth_table_scanner.sv
// Sweeps a 4-input function block through minterms 0..15, captures F into a truth table,
// counts zeros, and compares the result against a reference table.
module truth_table_scanner #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'hAAF8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  zero_count,
  output logic        match,
  output logic [3:0]  first_mismatch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] work_q, work_d;
  logic [4:0]  zc_q, zc_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  zo_q, zo_d;
  logic        match_q, match_d;
  logic [3:0]  fm_q, fm_d;

  logic        sample;
  logic [15:0] work_s;
  logic [4:0]  zc_s;
  logic [15:0] diff;
  logic [3:0]  lowest;

  // Working table/count as they will be after this edge; the DONE load uses
  // these so the final minterm is included in all four result registers.
  always_comb begin
    sample = (state_q == DRIVE) && (cnt_q == LAST_CNT);
    work_s = work_q;
    if (sample) begin
      work_s[idx_q] = F;
    end
    zc_s = zc_q + {4'b0000, sample & ~F};
    diff = work_s ^ EXPECTED;
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) begin
        lowest = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    zc_d    = zc_q;
    tbl_d   = tbl_q;
    zo_d    = zo_q;
    match_d = match_q;
    fm_d    = fm_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
          work_d  = 16'h0000;
          zc_d    = 5'd0;
        end
      end
      DRIVE: begin
        work_d = work_s;
        zc_d   = zc_s;
        if (sample) begin
          cnt_d = 4'd0;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            tbl_d   = work_s;
            zo_d    = zc_s;
            match_d = (diff == 16'h0000);
            fm_d    = lowest;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      work_q  <= 16'h0000;
      zc_q    <= 5'd0;
      tbl_q   <= 16'h0000;
      zo_q    <= 5'd0;
      match_q <= 1'b0;
      fm_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      zc_q    <= zc_d;
      tbl_q   <= tbl_d;
      zo_q    <= zo_d;
      match_q <= match_d;
      fm_q    <= fm_d;
    end
  end

  // Vector is forced to 0 outside DRIVE so the block under test idles at minterm 0.
  always_comb begin
    {A, B, C, D}   = (state_q == DRIVE) ? idx_q : 4'd0;
    busy           = (state_q == DRIVE);
    done           = (state_q == DONE);
    table_out      = tbl_q;
    zero_count     = zo_q;
    match          = match_q;
    first_mismatch = fm_q;
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: one SETTLE=1 scanner for functional/control checks, plus SETTLE=3 and
// SETTLE=2 scanners driven through a 2-cycle delayed reference function.
module tb_truth_table_scanner;

  typedef struct packed {
    logic [15:0] tbl;
    logic [4:0]  zc;
    logic        m;
    logic [3:0]  fm;
  } exp_t;

  localparam logic [15:0] REF_TBL = 16'hAAF8;

  logic clk = 1'b0;
  logic rst, start, start_s;
  int   mode;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  logic        f1, a1, b1, c1, d1, busy1, done1, match1;
  logic [15:0] tbl1;
  logic [4:0]  zc1;
  logic [3:0]  fm1;

  logic        f3, a3, b3, c3, d3, busy3, done3, match3;
  logic [15:0] tbl3;
  logic [4:0]  zc3;
  logic [3:0]  fm3;
  logic [1:0]  p3;

  logic        f2, a2, b2, c2, d2, busy2, done2, match2;
  logic [15:0] tbl2;
  logic [4:0]  zc2;
  logic [3:0]  fm2;
  logic [1:0]  p2;

  always #5 clk = ~clk;

  // Product of maxterms 0,1,2,8,10,12,14.
  function automatic logic ref_f(input logic [3:0] m);
    case (m)
      4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd12, 4'd14: ref_f = 1'b0;
      default:                                   ref_f = 1'b1;
    endcase
  endfunction

  function automatic exp_t model(input logic [15:0] t);
    exp_t e;
    e.tbl = t;
    e.zc  = 5'd0;
    e.fm  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!t[i]) e.zc = e.zc + 5'd1;
    end
    e.m = (t == REF_TBL);
    for (int i = 15; i >= 0; i--) begin
      if (t[i] != REF_TBL[i]) e.fm = 4'(i);
    end
    return e;
  endfunction

  function automatic logic fmode(input int md, input logic [3:0] m);
    case (md)
      0:       fmode = ref_f(m);
      1:       fmode = 1'b0;
      default: fmode = 1'b1;
    endcase
  endfunction

  always_comb f1 = fmode(mode, {a1, b1, c1, d1});
  always_ff @(posedge clk) p3 <= {p3[0], ref_f({a3, b3, c3, d3})};
  always_ff @(posedge clk) p2 <= {p2[0], ref_f({a2, b2, c2, d2})};
  assign f3 = p3[1];
  assign f2 = p2[1];

  truth_table_scanner #(.SETTLE(1), .EXPECTED(16'hAAF8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .F(f1),
    .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
    .table_out(tbl1), .zero_count(zc1), .match(match1), .first_mismatch(fm1)
  );

  truth_table_scanner #(.SETTLE(3), .EXPECTED(16'hAAF8)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_s), .F(f3),
    .A(a3), .B(b3), .C(c3), .D(d3), .busy(busy3), .done(done3),
    .table_out(tbl3), .zero_count(zc3), .match(match3), .first_mismatch(fm3)
  );

  truth_table_scanner #(.SETTLE(2), .EXPECTED(16'hAAF8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s), .F(f2),
    .A(a2), .B(b2), .C(c2), .D(d2), .busy(busy2), .done(done2),
    .table_out(tbl2), .zero_count(zc2), .match(match2), .first_mismatch(fm2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " abcd"}, {28'd0, a1, b1, c1, d1}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy1}, 32'd0);
    chk({tag, " done"}, {31'd0, done1}, 32'd0);
    chk({tag, " match"}, {31'd0, match1}, 32'd0);
    chk({tag, " table"}, {16'd0, tbl1}, 32'd0);
    chk({tag, " zcount"}, {27'd0, zc1}, 32'd0);
    chk({tag, " fmis"}, {28'd0, fm1}, 32'd0);
  endtask

  task automatic chk_result(input string tag, input exp_t e, input logic [15:0] t,
                            input logic [4:0] z, input logic m, input logic [3:0] f);
    chk({tag, " table"}, {16'd0, t}, {16'd0, e.tbl});
    chk({tag, " zcount"}, {27'd0, z}, {27'd0, e.zc});
    chk({tag, " match"}, {31'd0, m}, {31'd0, e.m});
    chk({tag, " fmis"}, {28'd0, f}, {28'd0, e.fm});
  endtask

  // Called at a negedge; start is accepted on the following posedge.
  task automatic scan1(input string tag, input int md, input bit pulse5);
    logic [15:0] t;
    exp_t e;
    mode = md;
    for (int i = 0; i < 16; i++) t[i] = fmode(md, 4'(i));
    sb_q.push_back(model(t));
    start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = pulse5 && (k == 5);
      chk({tag, " vec"}, {28'd0, a1, b1, c1, d1}, 32'(k - 1));
      chk({tag, " busy"}, {30'd0, busy1, done1}, 32'b10);
    end
    @(negedge clk);
    chk({tag, " done@16"}, {30'd0, busy1, done1}, 32'b01);
    chk({tag, " abcd idle"}, {28'd0, a1, b1, c1, d1}, 32'd0);
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk_result(tag, e, tbl1, zc1, match1, fm1);
    end
  endtask

  initial begin
    exp_t e;
    logic [15:0] t2;
    int lat3, lat2;
    rst = 1'b1;
    start = 1'b1;
    start_s = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset+start");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post-reset idle");

    scan1("ref", 0, 1'b0);
    scan1("const0", 1, 1'b0);
    scan1("const1", 2, 1'b1);
    @(negedge clk);
    chk("done holds", {30'd0, busy1, done1}, 32'b01);

    // Abort a scan at cycle 9 with reset; nothing partial may reach the outputs.
    mode = 0;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort pre vec", {28'd0, a1, b1, c1, d1}, 32'd8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    scan1("after abort", 0, 1'b0);

    // SETTLE=3 and SETTLE=2 scanners against a 2-cycle delayed reference.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    lat3 = -1;
    lat2 = -1;
    for (int c = 2; c <= 70; c++) begin
      @(negedge clk);
      if (done2 && lat2 < 0) lat2 = c - 1;
      if (done3 && lat3 < 0) begin
        lat3 = c - 1;
        break;
      end
    end
    chk("settle3 latency", 32'(lat3), 32'd48);
    chk("settle2 latency", 32'(lat2), 32'd32);
    e = model(REF_TBL);
    chk_result("settle3", e, tbl3, zc3, match3, fm3);
    for (int i = 1; i < 16; i++) t2[i] = ref_f(4'(i - 1));
    t2[0] = ref_f(4'd0);
    e = model(t2);
    chk_result("settle2", e, tbl2, zc2, match2, fm2);
    chk("settle2 wrong", {31'd0, tbl2 != REF_TBL}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
